// File: rtl/inst_seq_ctrl_if.sv
// Handshake and control bundle between the instruction sequencer and the
// datapath / memories it drives.
interface inst_seq_ctrl_if;
    logic       run;
    logic       if_req;
    logic       if_ack;
    logic       ir_we;
    logic [6:0] opcode;
    logic       reg_wr;
    logic       inst_invalid;
    logic       is_ebreak;
    logic       mem_req;
    logic       mem_wr;
    logic       mem_ack;
    logic       rf_we;
    logic       pc_we;
    logic       busy;
    logic       halted;
    logic       trap;
    logic [1:0] trap_cause;

    modport master (
        input  run, if_ack, opcode, reg_wr, inst_invalid, is_ebreak, mem_ack,
        output if_req, ir_we, mem_req, mem_wr, rf_we, pc_we,
               busy, halted, trap, trap_cause
    );

    modport slave (
        output run, if_ack, opcode, reg_wr, inst_invalid, is_ebreak, mem_ack,
        input  if_req, ir_we, mem_req, mem_wr, rf_we, pc_we,
               busy, halted, trap, trap_cause
    );
endinterface

// File: rtl/inst_seq_ctrl.sv
// Multi-cycle fetch/decode/mem/writeback sequencer for the RV64 datapath.
// Optional performance counters are enabled with `define INST_SEQ_PERF_CNT_EN.
module inst_seq_ctrl #(
    parameter int         TMO_W    = 8,
    parameter logic [6:0] LOAD_OP  = 7'b0000011,
    parameter logic [6:0] STORE_OP = 7'b0100011
) (
    input  logic           clk,
    input  logic           rst_n,
    inst_seq_ctrl_if.master bus
`ifdef INST_SEQ_PERF_CNT_EN
    ,
    output logic [63:0]    cycle_cnt,
    output logic [63:0]    instret_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        MEM,
        WB,
        HALT,
        TRAP
    } state_t;

    // The last wait cycle is the one where the counter would step to all-ones.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmoCnt_q, tmoCnt_d;
    logic [1:0]       cause_q, cause_d;

    logic ifReq, irWe, memReq, memWr, rfWe, pcWe, busy, halted, trap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tmoCnt_q <= '0;
            cause_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            tmoCnt_q <= tmoCnt_d;
            cause_q  <= cause_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmoCnt_d = tmoCnt_q;
        cause_d  = cause_q;
        ifReq    = 1'b0;
        irWe     = 1'b0;
        memReq   = 1'b0;
        memWr    = 1'b0;
        rfWe     = 1'b0;
        pcWe     = 1'b0;
        halted   = 1'b0;
        trap     = 1'b0;
        busy     = (state_q != IDLE) && (state_q != HALT) && (state_q != TRAP);

        case (state_q)
            IDLE: begin
                if (bus.run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                ifReq = 1'b1;
                if (bus.if_ack) begin
                    irWe     = 1'b1;
                    tmoCnt_d = '0;
                    state_d  = DECODE;
                end else if (tmoCnt_q == TMO_LAST) begin
                    tmoCnt_d = '0;
                    cause_d  = 2'd2;
                    state_d  = TRAP;
                end else begin
                    tmoCnt_d = tmoCnt_q + 1'b1;
                end
            end
            DECODE: begin
                if (bus.inst_invalid) begin
                    cause_d = 2'd1;
                    state_d = TRAP;
                end else if (bus.is_ebreak) begin
                    state_d = HALT;
                end else if ((bus.opcode == LOAD_OP) || (bus.opcode == STORE_OP)) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                memReq = 1'b1;
                memWr  = (bus.opcode == STORE_OP);
                if (bus.mem_ack) begin
                    tmoCnt_d = '0;
                    state_d  = WB;
                end else if (tmoCnt_q == TMO_LAST) begin
                    tmoCnt_d = '0;
                    cause_d  = 2'd3;
                    state_d  = TRAP;
                end else begin
                    tmoCnt_d = tmoCnt_q + 1'b1;
                end
            end
            WB: begin
                pcWe    = 1'b1;
                rfWe    = bus.reg_wr;
                state_d = bus.run ? FETCH : IDLE;
            end
            HALT: begin
                halted = 1'b1;
            end
            TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.if_req     = ifReq;
    assign bus.ir_we      = irWe;
    assign bus.mem_req    = memReq;
    assign bus.mem_wr     = memWr;
    assign bus.rf_we      = rfWe;
    assign bus.pc_we      = pcWe;
    assign bus.busy       = busy;
    assign bus.halted     = halted;
    assign bus.trap       = trap;
    assign bus.trap_cause = cause_q;

`ifdef INST_SEQ_PERF_CNT_EN
    logic [63:0] cycleCnt_q, instretCnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycleCnt_q   <= 64'd0;
            instretCnt_q <= 64'd0;
        end else begin
            if (busy) begin
                cycleCnt_q <= cycleCnt_q + 64'd1;
            end
            if (pcWe) begin
                instretCnt_q <= instretCnt_q + 64'd1;
            end
        end
    end

    assign cycle_cnt   = cycleCnt_q;
    assign instret_cnt = instretCnt_q;
`endif

endmodule
